// File: rtl/door_pkg.sv
// Shared types and widths for the door sequencer: state codes, state width
// and the width of the open-operation counter.
package door_pkg;

    localparam int STATE_W    = 3;
    localparam int OPEN_CNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_CLOSED    = 3'd0,
        ST_OPENING   = 3'd1,
        ST_OPEN_HOLD = 3'd2,
        ST_CLOSING   = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/door_sequencer_if.sv
// Sensor/button inputs and motor/status outputs of the door sequencer.
// The slave side is the sequencer; the master side drives the sensors.
interface door_sequencer_if;
    import door_pkg::*;

    logic                  c;
    logic                  h;
    logic                  p;
    logic                  obstacle;
    logic                  open_lim;
    logic                  closed_lim;
    logic                  fault_clr;
    logic                  motor_open;
    logic                  motor_close;
    logic                  alarm;
    logic [STATE_W-1:0]    state;
    logic [OPEN_CNT_W-1:0] open_cnt;

    modport master (
        output c, h, p, obstacle, open_lim, closed_lim, fault_clr,
        input  motor_open, motor_close, alarm, state, open_cnt
    );

    modport slave (
        input  c, h, p, obstacle, open_lim, closed_lim, fault_clr,
        output motor_open, motor_close, alarm, state, open_cnt
    );

endinterface

// File: rtl/door_open_request.sv
// Combinational open request: a person or the button asks to open,
// unless the lock is engaged.
module door_open_request (
    input  logic i_c,
    input  logic i_h,
    input  logic i_p,
    output logic o_req
);

    assign o_req = ~i_c & (i_h | i_p);

endmodule

// File: rtl/door_sequencer.sv
// Door motor sequencer: open, hold, close, reverse on obstacle/presence,
// motor timeout and limit-switch fault detection, open-operation counter.
module door_sequencer
    import door_pkg::*;
#(
    parameter int HOLD_CYCLES   = 8,
    parameter int MOTOR_TIMEOUT = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    door_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(MOTOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TIMER_ONE    = CNT_W'(1);
    localparam logic [OPEN_CNT_W-1:0] OPEN_ONE     = OPEN_CNT_W'(1);

    logic w_req;
    logic w_presence;
    logic w_rev;
    logic w_lim_fault;
    logic w_hold_restart;
    logic w_count_open;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_timer;
    logic [OPEN_CNT_W-1:0] r_open_cnt;
    logic                  r_motor_open;
    logic                  r_motor_close;
    logic                  r_alarm;

    door_open_request u_open_request (
        .i_c   (bus.c),
        .i_h   (bus.h),
        .i_p   (bus.p),
        .o_req (w_req)
    );

    // The lock only gates new requests; reversal while closing ignores it.
    assign w_presence  = bus.h | bus.p;
    assign w_rev       = bus.obstacle | w_presence;
    assign w_lim_fault = bus.open_lim & bus.closed_lim;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CLOSED: begin
                if (w_req)
                    w_next_state = ST_OPENING;
            end
            ST_OPENING: begin
                if (bus.open_lim)
                    w_next_state = ST_OPEN_HOLD;
                else if (r_timer == TIMEOUT_LAST)
                    w_next_state = ST_FAULT;
            end
            ST_OPEN_HOLD: begin
                if (!w_presence && r_timer == HOLD_LAST)
                    w_next_state = ST_CLOSING;
            end
            ST_CLOSING: begin
                if (bus.closed_lim)
                    w_next_state = ST_CLOSED;
                else if (w_rev)
                    w_next_state = ST_OPENING;
                else if (r_timer == TIMEOUT_LAST)
                    w_next_state = ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.fault_clr)
                    w_next_state = ST_CLOSING;
            end
            default: w_next_state = ST_FAULT;
        endcase

        // Both limit switches closed at once means a broken sensor.
        if (r_state != ST_FAULT && w_lim_fault)
            w_next_state = ST_FAULT;
    end

    assign w_hold_restart = (r_state == ST_OPEN_HOLD) && w_presence;
    assign w_count_open   = (w_next_state == ST_OPENING) &&
                            (r_state == ST_CLOSED || r_state == ST_CLOSING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_CLOSED;
            r_timer       <= '0;
            r_open_cnt    <= '0;
            r_motor_open  <= 1'b0;
            r_motor_close <= 1'b0;
            r_alarm       <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_next_state != r_state || w_hold_restart)
                r_timer <= '0;
            else if (r_timer != '1)
                r_timer <= r_timer + TIMER_ONE;

            if (w_count_open)
                r_open_cnt <= r_open_cnt + OPEN_ONE;

            r_motor_open  <= (w_next_state == ST_OPENING);
            r_motor_close <= (w_next_state == ST_CLOSING);
            r_alarm       <= (w_next_state == ST_FAULT);
        end
    end

    assign bus.state       = r_state;
    assign bus.open_cnt    = r_open_cnt;
    assign bus.motor_open  = r_motor_open;
    assign bus.motor_close = r_motor_close;
    assign bus.alarm       = r_alarm;

endmodule
